// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int DATA_W = 32;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and load/store requesters.
// When both request, i_pref names the winner; otherwise the lone requester wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_if_valid,
    input  logic i_ls_valid,
    input  logic i_pref,
    output logic o_grant_id,
    output logic o_grant_valid
);

    always_comb begin
        o_grant_valid = i_if_valid | i_ls_valid;
        o_grant_id    = OWN_IF;
        if (i_if_valid && i_ls_valid) begin
            o_grant_id = i_pref;
        end else if (i_ls_valid) begin
            o_grant_id = OWN_LS;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one RAM between fetch and load/store ports.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed ls-over-if priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_resp_data,
    input  logic              if_resp_ready,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              ls_we,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_resp_valid,
    output logic [DATA_W-1:0] ls_resp_data,
    input  logic              ls_resp_ready,
    output logic              ram_ce,
    output logic              ram_data_le,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);
    import mem_arb_pkg::*;

    state_t             r_state;
    logic               r_owner;
    logic               r_ram_ce;
    logic               r_ram_le;
    logic               r_if_resp_valid;
    logic               r_ls_resp_valid;
    logic [ADDR_W-1:0]  r_ram_address;
    logic [DATA_W-1:0]  r_ram_data_in;
    logic [DATA_W-1:0]  r_resp_data;

    logic               w_pref;
    logic               w_grant_id;
    logic               w_grant_valid;
    logic               w_hs;
    logic               w_owner_ready;

    mem_arb_pick u_pick (
        .i_if_valid    (if_req_valid),
        .i_ls_valid    (ls_req_valid),
        .i_pref        (w_pref),
        .o_grant_id    (w_grant_id),
        .o_grant_valid (w_grant_valid)
    );

`ifdef MEM_ARB_RR_EN
    // Preferred requester flips to whoever lost the most recent grant.
    logic r_pref;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pref <= OWN_LS;
        end else if (w_hs) begin
            r_pref <= ~w_grant_id;
        end
    end
    assign w_pref = r_pref;
`else
    assign w_pref = OWN_LS;
`endif

    assign w_hs          = (r_state == IDLE) && w_grant_valid;
    assign if_req_ready  = w_hs && (w_grant_id == OWN_IF);
    assign ls_req_ready  = w_hs && (w_grant_id == OWN_LS);
    assign w_owner_ready = (r_owner == OWN_LS) ? ls_resp_ready : if_resp_ready;

    // RAM strobes are registers cleared by the async reset, so an aborted access drops at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_owner         <= OWN_IF;
            r_ram_ce        <= 1'b0;
            r_ram_le        <= 1'b0;
            r_if_resp_valid <= 1'b0;
            r_ls_resp_valid <= 1'b0;
            r_ram_address   <= '0;
            r_ram_data_in   <= '0;
            r_resp_data     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_owner  <= w_grant_id;
                        r_ram_ce <= 1'b1;
                        if (w_grant_id == OWN_LS) begin
                            r_ram_address <= ls_addr;
                            r_ram_data_in <= ls_wdata;
                            r_ram_le      <= ls_we;
                        end else begin
                            r_ram_address <= if_addr;
                            r_ram_le      <= 1'b0;
                        end
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_ram_ce        <= 1'b0;
                    r_ram_le        <= 1'b0;
                    r_resp_data     <= r_ram_le ? '0 : ram_data_out;
                    r_if_resp_valid <= (r_owner == OWN_IF);
                    r_ls_resp_valid <= (r_owner == OWN_LS);
                    r_state         <= RESP;
                end
                RESP: begin
                    if (w_owner_ready) begin
                        r_if_resp_valid <= 1'b0;
                        r_ls_resp_valid <= 1'b0;
                        r_state         <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ram_ce        = r_ram_ce;
    assign ram_data_le   = r_ram_le;
    assign ram_address   = r_ram_address;
    assign ram_data_in   = r_ram_data_in;
    assign if_resp_valid = r_if_resp_valid;
    assign ls_resp_valid = r_ls_resp_valid;
    assign if_resp_data  = r_resp_data;
    assign ls_resp_data  = r_resp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, contention, random traffic
// against a word-array reference model, and reset during an access.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready;
    logic [31:0] if_addr;
    logic        if_resp_valid, if_resp_ready;
    logic [31:0] if_resp_data;
    logic        ls_req_valid, ls_req_ready, ls_we;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_resp_valid, ls_resp_ready;
    logic [31:0] ls_resp_data;
    logic        ram_ce, ram_data_le;
    logic [31:0] ram_address, ram_data_in, ram_data_out;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data), .if_resp_ready(if_resp_ready),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_we(ls_we), .ls_wdata(ls_wdata),
        .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data), .ls_resp_ready(ls_resp_ready),
        .ram_ce(ram_ce), .ram_data_le(ram_data_le), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    // RAM environment: 64 words, combinational read, write on clock edge.
    logic [31:0] ram [0:63];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;
    assign ram_data_out = ram[ram_address[7:2]];
    always @(posedge clk) begin
        if (ram_ce && ram_data_le) ram[ram_address[7:2]] <= ram_data_in;
        else if (pre_we) ram[pre_idx] <= pre_data;
    end

    // Reference model state.
    logic [31:0] ref_mem [0:63];
    logic        last_granted;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic model_pick(input logic ifv, input logic lsv);
        if (ifv && !lsv) return OWN_IF;
        if (lsv && !ifv) return OWN_LS;
`ifdef MEM_ARB_RR_EN
        return (last_granted == OWN_LS) ? OWN_IF : OWN_LS;
`else
        return OWN_LS;
`endif
    endfunction

    // One full transaction; starts shortly after a rising edge with the DUT idle.
    task automatic do_txn(input logic ifv, input logic [31:0] ia, input logic lsv,
                          input logic we, input logic [31:0] la, input logic [31:0] wd,
                          input int stall, input logic keep,
                          output logic own, output logic [31:0] data);
        logic        got = 1'b0;
        logic [1:0]  vsnap;
        logic [31:0] dsnap;
        own  = OWN_IF;
        data = '0;
        if_req_valid = ifv; if_addr = ia;
        ls_req_valid = lsv; ls_we = we; ls_addr = la; ls_wdata = wd;
        if_resp_ready = 1'b0; ls_resp_ready = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if ((if_req_valid && if_req_ready) || (ls_req_valid && ls_req_ready)) begin
                got = 1'b1;
                check("single_grant", {31'b0, if_req_ready & ls_req_ready}, 32'd0);
                own = (ls_req_valid && ls_req_ready) ? OWN_LS : OWN_IF;
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            n_checks++; n_errors++;
            $display("FAIL hs_timeout: got no handshake expected one within 10 cycles");
            if_req_valid = 1'b0; ls_req_valid = 1'b0;
            return;
        end
        if (!keep) begin
            if_req_valid = 1'b0; ls_req_valid = 1'b0;
        end
        #1;
        check("access_ce", {31'b0, ram_ce}, 32'd1);
        check("access_le", {31'b0, ram_data_le}, {31'b0, (own == OWN_LS) && we});
        check("access_addr", ram_address, (own == OWN_LS) ? la : ia);
        if (own == OWN_LS && we) check("access_wdata", ram_data_in, wd);
        check("access_ready", {30'b0, if_req_ready, ls_req_ready}, 32'd0);
        @(posedge clk); #2;
        check("resp_valid", {30'b0, if_resp_valid, ls_resp_valid},
              (own == OWN_LS) ? 32'd1 : 32'd2);
        data  = (own == OWN_LS) ? ls_resp_data : if_resp_data;
        vsnap = {if_resp_valid, ls_resp_valid};
        dsnap = data;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #2;
            check("stall_valid", {30'b0, if_resp_valid, ls_resp_valid}, {30'b0, vsnap});
            check("stall_data", (own == OWN_LS) ? ls_resp_data : if_resp_data, dsnap);
            check("stall_ce", {31'b0, ram_ce}, 32'd0);
            check("stall_ready", {30'b0, if_req_ready, ls_req_ready}, 32'd0);
        end
        if (own == OWN_LS) ls_resp_ready = 1'b1; else if_resp_ready = 1'b1;
        @(posedge clk); #1;
        if_resp_ready = 1'b0; ls_resp_ready = 1'b0;
        #1;
        check("resp_done", {30'b0, if_resp_valid, ls_resp_valid}, 32'd0);
    endtask

    task automatic apply_reset();
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_granted = OWN_IF;
    endtask

    typedef struct {
        string       nm;
        logic        ifv;
        logic [31:0] ia;
        logic        lsv;
        logic        we;
        logic [31:0] la;
        logic [31:0] wd;
        int          stall;
        logic        exp_own;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        own, exp_own;
        logic [31:0] data, exp_data, wd;
        logic        ifv, lsv, we;
        logic [31:0] ia, la;
        int          kind;

        tbl[0] = '{"fetch_10",   1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,         0, OWN_IF, 32'hDEADBEEF};
        tbl[1] = '{"store_4",    1'b0, 32'h0,  1'b1, 1'b1, 32'h4,  32'h12345678,  0, OWN_LS, 32'h0};
        tbl[2] = '{"load_4",     1'b0, 32'h0,  1'b1, 1'b0, 32'h4,  32'h0,         0, OWN_LS, 32'h12345678};
        tbl[3] = '{"fetch_bp",   1'b1, 32'h4,  1'b0, 1'b0, 32'h0,  32'h0,         5, OWN_IF, 32'h12345678};
        tbl[4] = '{"store_20",   1'b0, 32'h0,  1'b1, 1'b1, 32'h20, 32'hCAFEF00D,  2, OWN_LS, 32'h0};
        tbl[5] = '{"fetch_20",   1'b1, 32'h20, 1'b0, 1'b0, 32'h0,  32'h0,         1, OWN_IF, 32'hCAFEF00D};

        rst = 1'b1;
        if_req_valid = 1'b0; if_addr = '0; if_resp_ready = 1'b0;
        ls_req_valid = 1'b0; ls_addr = '0; ls_we = 1'b0; ls_wdata = '0; ls_resp_ready = 1'b0;
        pre_we = 1'b0; pre_idx = '0; pre_data = '0;
        last_granted = OWN_IF;

        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            pre_we   = 1'b1;
            pre_idx  = i[5:0];
            pre_data = (i == 4) ? 32'hDEADBEEF : (32'h1000_0000 + i * 32'h0001_0101);
            ref_mem[i] = pre_data;
        end
        @(negedge clk);
        pre_we = 1'b0;

        @(posedge clk); #2;
        check("rst_resp_valid", {30'b0, if_resp_valid, ls_resp_valid}, 32'd0);
        check("rst_ram_ce", {31'b0, ram_ce}, 32'd0);
        check("rst_ram_le", {31'b0, ram_data_le}, 32'd0);
        check("rst_ram_addr", ram_address, 32'd0);
        check("rst_ram_din", ram_data_in, 32'd0);
        check("rst_resp_data", if_resp_data, 32'd0);
        check("rst_ready", {30'b0, if_req_ready, ls_req_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) begin
            #1;
            check("idle_no_ce", {31'b0, ram_ce}, 32'd0);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 6; i++) begin
            do_txn(tbl[i].ifv, tbl[i].ia, tbl[i].lsv, tbl[i].we, tbl[i].la, tbl[i].wd,
                   tbl[i].stall, 1'b0, own, data);
            $display("txn %s owner=%0d data=%h", tbl[i].nm, own, data);
            check({tbl[i].nm, "_owner"}, {31'b0, own}, {31'b0, tbl[i].exp_own});
            check({tbl[i].nm, "_data"}, data, tbl[i].exp_data);
            if (tbl[i].lsv && tbl[i].we) ref_mem[tbl[i].la[7:2]] = tbl[i].wd;
            last_granted = tbl[i].exp_own;
        end

        apply_reset();
        for (int k = 0; k < 4; k++) begin
            exp_own  = model_pick(1'b1, 1'b1);
            exp_data = (exp_own == OWN_LS) ? ref_mem[1] : ref_mem[4];
            do_txn(1'b1, 32'h10, 1'b1, 1'b0, 32'h4, 32'h0, 0, 1'b1, own, data);
            $display("txn contend_%0d owner=%0d data=%h", k, own, data);
            check("contend_owner", {31'b0, own}, {31'b0, exp_own});
            check("contend_data", data, exp_data);
            last_granted = exp_own;
        end
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            ifv  = (kind != 1);
            lsv  = (kind != 0);
            we   = $urandom_range(0, 1) == 1;
            ia   = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
            la   = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
            wd   = $urandom;
            exp_own  = model_pick(ifv, lsv);
            exp_data = (exp_own == OWN_LS) ? (we ? 32'h0 : ref_mem[la[7:2]]) : ref_mem[ia[7:2]];
            do_txn(ifv, ia, lsv, we, la, wd, $urandom_range(0, 3), 1'b0, own, data);
            $display("txn rand_%0d owner=%0d data=%h", n, own, data);
            check("rand_owner", {31'b0, own}, {31'b0, exp_own});
            check("rand_data", data, exp_data);
            if (exp_own == OWN_LS && we) ref_mem[la[7:2]] = wd;
            last_granted = exp_own;
        end

        // Store to 0x8 aborted by reset while in ACCESS.
        wd = ~ref_mem[2];
        ls_req_valid = 1'b1; ls_we = 1'b1; ls_addr = 32'h8; ls_wdata = wd;
        if_req_valid = 1'b0;
        #1;
        check("abort_hs", {31'b0, ls_req_ready}, 32'd1);
        @(posedge clk); #1;
        ls_req_valid = 1'b0;
        #1;
        check("abort_ce_before", {31'b0, ram_ce}, 32'd1);
        check("abort_le_before", {31'b0, ram_data_le}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("abort_ce_drop", {31'b0, ram_ce}, 32'd0);
        check("abort_le_drop", {31'b0, ram_data_le}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        last_granted = OWN_IF;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("abort_no_resp", {30'b0, if_resp_valid, ls_resp_valid}, 32'd0);
            check("abort_no_ce", {31'b0, ram_ce}, 32'd0);
            @(posedge clk); #1;
        end
        check("abort_word8", ram[2], ref_mem[2]);
        do_txn(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 0, 1'b0, own, data);
        $display("txn load_8_after_abort owner=%0d data=%h", own, data);
        check("abort_load_owner", {31'b0, own}, {31'b0, OWN_LS});
        check("abort_load_data", data, ref_mem[2]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width forwarded to the RAM.
REQ-002 Parameter DATA_W, default 32, word width; fixed at 32.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 if_req_valid  in  1  fetch request; if_req_ready out 1 fetch accepted; if_addr in ADDR_W fetch address.
REQ-006 if_resp_valid  out  1  fetch data valid; if_resp_data out 32; if_resp_ready in 1 consumer accepts.
REQ-007 ls_req_valid  in  1  load/store request; ls_req_ready out 1; ls_addr in ADDR_W; ls_we in 1 (1=store); ls_wdata in 32.
REQ-008 ls_resp_valid  out  1  load/store done; ls_resp_data out 32 (load data, 0 for stores); ls_resp_ready in 1.
REQ-009 ram_ce, ram_data_le  out  1  RAM enable and write strobe; ram_address out ADDR_W; ram_data_in out 32; ram_data_out in 32 (combinational read).

Function
REQ-010 FSM states IDLE, ACCESS, RESP; exactly one transaction in flight.
REQ-011 IDLE: req_ready of the granted requester SHALL be 1 combinationally when its valid is 1 and the other is not granted; handshake = valid&&ready same cycle.
REQ-012 On handshake, address, we, wdata and owner ID SHALL be registered; next state ACCESS.
REQ-013 ACCESS (one cycle): ram_ce=1, ram_address=latched address, ram_data_in=latched wdata, ram_data_le=latched we; read data captured from ram_data_out at end of cycle; next state RESP.
REQ-014 Outside ACCESS, ram_ce and ram_data_le SHALL be 0; ram_address and ram_data_in hold last value.
REQ-015 RESP: owner's resp_valid=1 with captured data (stores return 0); held stable until owner's resp_ready=1, then next state IDLE.
REQ-016 Min latency: handshake cycle N -> resp_valid in cycle N+2; back-to-back throughput one transaction per 3 cycles.
REQ-017 Both req_ready SHALL be 0 in ACCESS and RESP; new requests wait.
REQ-018 Default arbitration (macro absent): fixed priority, ls wins over if when both valid in IDLE.
REQ-019 Requester dropping valid before handshake SHALL cause no RAM access.
REQ-020 Addresses forwarded unmodified; no alignment check, no wrap handling beyond ADDR_W truncation.
REQ-021 Non-owner resp_valid SHALL be 0 at all times.

Reset
REQ-022 rst asserted: state=IDLE, all resp_valid=0, ram_ce=0, ram_data_le=0, ram_address=0, ram_data_in=0, resp data regs=0, round-robin pointer=ls-preferred.
REQ-023 rst mid-ACCESS SHALL abort immediately; no write may complete after rst rises; pending response discarded.

Configuration
REQ-024 Macro MEM_ARB_RR_EN defined: round-robin; when both valid in IDLE, grant the requester not granted last; pointer updates on each handshake.
REQ-025 MEM_ARB_RR_EN undefined: fixed priority per REQ-018; no pointer register synthesised.

Structure
REQ-026 Package mem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), owner ID constants (OWN_IF=0, OWN_LS=1) and DATA_W.
REQ-027 One sub-module mem_arb_pick SHALL implement grant selection (inputs: both valids, pointer; output: grant ID, grant valid); FSM and datapath stay in mem_arbiter.

Verification
REQ-028 Fetch only: if_addr=0x10, RAM word 0xDEADBEEF -> if_resp_valid at N+2, if_resp_data=0xDEADBEEF, ram_data_le never 1.
REQ-029 Store then load: ls store 0x0000_0004<=0x12345678 -> one-cycle ram_data_le=1 in ACCESS, ls_resp_data=0; subsequent load of 0x4 returns 0x12345678.
REQ-030 Contention, macro absent: both valid every cycle for 4 transactions -> all 4 granted to ls, if starved.
REQ-031 Contention, MEM_ARB_RR_EN: both valid for 4 transactions -> grants ls, if, ls, if.
REQ-032 Backpressure: if_resp_ready=0 for 5 cycles in RESP -> if_resp_valid and data stable, both req_ready=0, no ram_ce.
REQ-033 Reset mid-ACCESS of store to 0x8: rst rises during ACCESS -> ram_ce/ram_data_le drop same cycle, word 0x8 unchanged, no resp_valid after release.
